// File: rtl/mac_dot_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mac_dot_ctrl                                               |
// | Description : Signed 8x8 multiply-accumulate dot-product controller.     |
// |               Captures an initial partial sum and a length, accumulates  |
// |               that many (ifmap, filter) products into a 24-bit wrapping  |
// |               accumulator, then holds the result until it is consumed.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mac_dot_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [23:0]      psum_init,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       ifmap,
    input  logic [7:0]       filter,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      result,
    output logic             busy
);

    // State encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [LEN_W-1:0] c_len_one  = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_len_zero = '0;

    logic [1:0]        r_state;
    logic [23:0]       r_acc;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [23:0]       r_result;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_busy;

    logic signed [15:0] w_prod;
    logic [23:0]        w_prod_ext;
    logic [23:0]        w_sum;
    logic               w_beat;
    logic               w_last;

    // Full-precision signed product, sign-extended and added modulo 2^24
    assign w_prod     = $signed(ifmap) * $signed(filter);
    assign w_prod_ext = {{8{w_prod[15]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // in_ready is only ever high in RUN, so it qualifies the handshake alone
    assign w_beat = in_valid && r_in_ready;
    assign w_last = (r_cnt == (r_len - c_len_one));

    // Control FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_acc       <= '0;
            r_cnt       <= c_len_zero;
            r_len       <= c_len_zero;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (abort) begin
            // Abort beats any in-flight beat: acc and result are left as-is
            r_state     <= c_st_idle;
            r_cnt       <= c_len_zero;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_acc  <= psum_init;
                        r_cnt  <= c_len_zero;
                        r_len  <= len;
                        r_busy <= 1'b1;
                        if (len != c_len_zero) begin
                            r_state    <= c_st_run;
                            r_in_ready <= 1'b1;
                        end else begin
                            // Empty vector: the initial sum is the answer
                            r_state     <= c_st_done;
                            r_result    <= psum_init;
                            r_out_valid <= 1'b1;
                        end
                    end
                end

                c_st_run: begin
                    if (w_beat) begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + c_len_one;
                        if (w_last) begin
                            r_state     <= c_st_done;
                            r_in_ready  <= 1'b0;
                            r_result    <= w_sum;
                            r_out_valid <= 1'b1;
                        end
                    end
                end

                c_st_done: begin
                    if (out_ready) begin
                        r_state     <= c_st_idle;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= c_st_idle;
                    r_cnt       <= c_len_zero;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mac_dot_ctrl                                            |
// | Description : Directed self-checking bench for mac_dot_ctrl.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mac_dot_ctrl;

    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [23:0]      psum_init;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       ifmap;
    logic [7:0]       filter;
    logic             out_valid;
    logic             out_ready;
    logic [23:0]      result;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    mac_dot_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .psum_init (psum_init),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ifmap     (ifmap),
        .filter    (filter),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        ifmap    = a;
        filter   = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; psum_init = '0; abort = 1'b0;
        in_valid = 1'b0; ifmap = '0; filter = '0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);

        // Nominal: 3*4 + -2*5 + 127*127 = 16131
        start = 1'b1; len = 8'd3; psum_init = 24'd0;
        tick();
        start = 1'b0;
        check("nom_in_ready", 32'(in_ready), 32'd1);
        check("nom_busy",     32'(busy),     32'd1);
        beat(8'd3, 8'd4);
        beat(8'hFE, 8'd5);
        check("nom_no_early_valid", 32'(out_valid), 32'd0);
        beat(8'd127, 8'd127);
        check("nom_out_valid", 32'(out_valid), 32'd1);
        check("nom_result",    32'(result),    32'h003F03);
        check("nom_ready_off", 32'(in_ready),  32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("nom_idle_busy",  32'(busy),      32'd0);
        check("nom_idle_valid", 32'(out_valid), 32'd0);
        check("nom_hold_result", 32'(result),   32'h003F03);

        // Zero length goes straight to DONE with psum_init
        start = 1'b1; len = 8'd0; psum_init = 24'h000123;
        tick();
        check("zl_out_valid", 32'(out_valid), 32'd1);
        check("zl_result",    32'(result),    32'h000123);
        check("zl_in_ready",  32'(in_ready),  32'd0);
        // Start held together with out_ready in DONE must be ignored
        len = 8'd5; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("zl_start_ignored_busy", 32'(busy),     32'd0);
        check("zl_start_ignored_rdy",  32'(in_ready), 32'd0);

        // Wrap: 0xFFFFFF + 16384 = 0x1003FFF -> 0x003FFF
        start = 1'b1; len = 8'd1; psum_init = 24'hFFFFFF;
        tick();
        start = 1'b0;
        beat(8'h80, 8'h80);
        check("wrap_valid",  32'(out_valid), 32'd1);
        check("wrap_result", 32'(result),    32'h003FFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-pressure: 10*10 + (-3)*7 = 79, gap with a stray start in RUN
        start = 1'b1; len = 8'd2; psum_init = 24'd0;
        tick();
        start = 1'b0;
        beat(8'd10, 8'd10);
        start = 1'b1; len = 8'd9; psum_init = 24'h0ABCDE;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_gap_ready", 32'(in_ready),  32'd1);
            check("bp_gap_valid", 32'(out_valid), 32'd0);
        end
        start = 1'b0;
        beat(8'hFD, 8'd7);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid",  32'(out_valid), 32'd1);
            check("bp_hold_result", 32'(result),    32'd79);
            tick();
        end
        check("bp_still_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", 32'(busy), 32'd0);

        // Abort on the 2nd beat
        start = 1'b1; len = 8'd4; psum_init = 24'd0;
        tick();
        start = 1'b0;
        beat(8'd1, 8'd1);
        abort = 1'b1;
        beat(8'd5, 8'd5);
        abort = 1'b0;
        check("ab_busy",   32'(busy),      32'd0);
        check("ab_ready",  32'(in_ready),  32'd0);
        check("ab_valid",  32'(out_valid), 32'd0);
        check("ab_result", 32'(result),    32'd79);
        tick();
        tick();
        check("ab_valid_later", 32'(out_valid), 32'd0);
        start = 1'b1; len = 8'd1; psum_init = 24'd0;
        tick();
        start = 1'b0;
        beat(8'd2, 8'd3);
        check("ab_next_valid",  32'(out_valid), 32'd1);
        check("ab_next_result", 32'(result),    32'h000006);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-run, with start and abort also high during reset
        start = 1'b1; len = 8'd4; psum_init = 24'd0;
        tick();
        start = 1'b0;
        beat(8'd1, 8'd2);
        beat(8'd3, 8'd4);
        rst_n = 1'b0; start = 1'b1; abort = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        check("mr_busy",   32'(busy),      32'd0);
        check("mr_ready",  32'(in_ready),  32'd0);
        check("mr_valid",  32'(out_valid), 32'd0);
        check("mr_result", 32'(result),    32'd0);
        start = 1'b1; len = 8'd1; psum_init = 24'd0;
        tick();
        start = 1'b0;
        beat(8'd1, 8'd1);
        check("mr_next_valid",  32'(out_valid), 32'd1);
        check("mr_next_result", 32'(result),    32'h000001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mr_final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
